// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Defining ALU_SHARE_ARB_PERF_EN adds saturating grant/conflict performance counters.
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             p0_req_valid,
    output logic             p0_req_ready,
    input  logic [WIDTH-1:0] p0_a,
    input  logic [WIDTH-1:0] p0_b,
    input  logic [2:0]       p0_func,
    input  logic             p0_sub_sra,
    output logic             p0_rsp_valid,
    input  logic             p0_rsp_ready,
    output logic [WIDTH-1:0] p0_rsp_q,
    output logic [2:0]       p0_rsp_flags,

    input  logic             p1_req_valid,
    output logic             p1_req_ready,
    input  logic [WIDTH-1:0] p1_a,
    input  logic [WIDTH-1:0] p1_b,
    input  logic [2:0]       p1_func,
    input  logic             p1_sub_sra,
    output logic             p1_rsp_valid,
    input  logic             p1_rsp_ready,
    output logic [WIDTH-1:0] p1_rsp_q,
    output logic [2:0]       p1_rsp_flags,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_func,
    output logic             alu_sub_sra,
    input  logic [WIDTH-1:0] alu_q,
    input  logic             alu_eq,
    input  logic             alu_lt,
    input  logic             alu_ltu
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_grant0,
    output logic [CNT_W-1:0] perf_grant1,
    output logic [CNT_W-1:0] perf_conflict
`endif
);

    logic             pending0;
    logic             pending1;
    logic             last_grant;
    logic             elig0;
    logic             elig1;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             hs0;
    logic             hs1;

    logic             stage_valid;
    logic             stage_tag;
    logic [WIDTH-1:0] stage_a;
    logic [WIDTH-1:0] stage_b;
    logic [2:0]       stage_func;
    logic             stage_sub_sra;

    // Ready is suppressed during reset so nothing is advertised while state is cleared.
    always_comb begin
        elig0  = p0_req_valid & ~pending0;
        elig1  = p1_req_valid & ~pending1;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (elig0 && elig1) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign accept       = grant0 | grant1;
    assign p0_req_ready = grant0;
    assign p1_req_ready = grant1;
    assign hs0          = p0_rsp_valid & p0_rsp_ready;
    assign hs1          = p1_rsp_valid & p1_rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending0   <= 1'b0;
            pending1   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (grant0)
                pending0 <= 1'b1;
            else if (hs0)
                pending0 <= 1'b0;

            if (grant1)
                pending1 <= 1'b1;
            else if (hs1)
                pending1 <= 1'b0;

            if (accept)
                last_grant <= grant1;
        end
    end

    // Stage registers only reload on an acceptance, so the ALU inputs hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid   <= 1'b0;
            stage_tag     <= 1'b0;
            stage_a       <= '0;
            stage_b       <= '0;
            stage_func    <= '0;
            stage_sub_sra <= 1'b0;
        end else begin
            stage_valid <= accept;
            if (accept) begin
                stage_tag     <= grant1;
                stage_a       <= grant1 ? p1_a       : p0_a;
                stage_b       <= grant1 ? p1_b       : p0_b;
                stage_func    <= grant1 ? p1_func    : p0_func;
                stage_sub_sra <= grant1 ? p1_sub_sra : p0_sub_sra;
            end
        end
    end

    assign alu_a       = stage_a;
    assign alu_b       = stage_b;
    assign alu_func    = stage_func;
    assign alu_sub_sra = stage_sub_sra;

    // A port's slot is always empty when its op reaches capture, thanks to pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rsp_valid <= 1'b0;
            p0_rsp_q     <= '0;
            p0_rsp_flags <= '0;
        end else if (stage_valid && !stage_tag) begin
            p0_rsp_valid <= 1'b1;
            p0_rsp_q     <= alu_q;
            p0_rsp_flags <= {alu_ltu, alu_lt, alu_eq};
        end else if (hs0) begin
            p0_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_rsp_valid <= 1'b0;
            p1_rsp_q     <= '0;
            p1_rsp_flags <= '0;
        end else if (stage_valid && stage_tag) begin
            p1_rsp_valid <= 1'b1;
            p1_rsp_q     <= alu_q;
            p1_rsp_flags <= {alu_ltu, alu_lt, alu_eq};
        end else if (hs1) begin
            p1_rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SHARE_ARB_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant0 && !(&perf_grant0))
                perf_grant0 <= perf_grant0 + CNT_ONE;
            if (grant1 && !(&perf_grant1))
                perf_grant1 <= perf_grant1 + CNT_ONE;
            if (elig0 && elig1 && !(&perf_conflict))
                perf_conflict <= perf_conflict + CNT_ONE;
        end
    end
`endif

endmodule
